// File: rtl/ddr_app_pkg.sv
// Shared types and constants for the DDR application-interface tester.
package ddr_app_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrAddr,
        StRdAddr,
        StRdData,
        StDone
    } state_e;

    localparam logic ModeIncr = 1'b0;
    localparam logic ModeLfsr = 1'b1;

    localparam logic [31:0] LfsrPoly     = 32'h8020_0003;
    localparam logic [15:0] TimeoutLimit = 16'd4096;

    // Right-shifting Galois LFSR step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LfsrPoly : 32'h0);
    endfunction

endpackage

// File: rtl/ddr_pattern_gen.sv
// Test pattern generator: incrementing count or Galois LFSR, replicated across 32-bit lanes.
module ddr_pattern_gen
    import ddr_app_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = 32'h0000_0001
) (
    input  logic                  app_clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int unsigned Lanes = DATA_WIDTH / 32;

    logic [31:0] state_q;
    logic        mode_q;

    always_ff @(posedge app_clk) begin
        if (rst) begin
            state_q <= '0;
            mode_q  <= ModeIncr;
        end else if (load) begin
            state_q <= SEED;
            mode_q  <= mode;
        end else if (advance) begin
            state_q <= (mode_q == ModeLfsr) ? lfsr_next(state_q) : state_q + 32'd1;
        end
    end

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < Lanes; k++) begin
            word[k*32 +: 32] = (mode_q == ModeLfsr) ? (state_q ^ 32'(k)) : state_q;
        end
    end

endmodule

// File: rtl/ddr_app_tester.sv
// Write-then-readback tester for a DDR controller application interface.
// Define DDR_APP_TESTER_TIMEOUT_EN to enable the read-data watchdog.
module ddr_app_tester
    import ddr_app_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 30,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           BURST_LEN  = 32,
    parameter int unsigned           NUM_BURSTS = 100,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter logic [31:0]           SEED       = 32'h0000_0001
) (
    input  logic                  app_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] app_data_wr,
    output logic                  app_data_wr_valid,
    input  logic                  app_data_wr_ready,
    output logic [ADDR_WIDTH-1:0] app_addr_wr,
    output logic                  app_addr_wr_valid,
    input  logic                  app_addr_wr_ready,
    output logic [ADDR_WIDTH-1:0] app_addr_rd,
    output logic                  app_addr_rd_valid,
    input  logic                  app_addr_rd_ready,
    input  logic [DATA_WIDTH-1:0] app_data_rd,
    input  logic                  app_data_rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout
);

    localparam int unsigned           BeatBytes  = DATA_WIDTH / 8;
    localparam int unsigned           BeatW      = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_WIDTH-1:0] BurstBytes = ADDR_WIDTH'(BURST_LEN * BeatBytes);
    localparam logic [BeatW-1:0]      LastBeat   = BeatW'(BURST_LEN - 1);
    localparam logic [15:0]           LastBurst  = 16'(NUM_BURSTS - 1);

    state_e                  state_q, state_d;
    logic [BeatW-1:0]        beat_q;
    logic [15:0]             burst_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             err_cnt_q;
    logic [ADDR_WIDTH-1:0]   first_err_q;
    logic                    pass_q;
    logic                    start_ok;
    logic                    wr_fire;
    logic                    rd_beat;
    logic                    mismatch;
    logic                    timeout_hit;
    logic [DATA_WIDTH-1:0]   exp_word;
    logic [ADDR_WIDTH-1:0]   beat_addr;

    assign start_ok  = (state_q == StIdle) && start;
    assign wr_fire   = (state_q == StWrData) && app_data_wr_ready;
    assign rd_beat   = (state_q == StRdData) && app_data_rd_valid;
    assign mismatch  = rd_beat && (app_data_rd != exp_word);
    assign beat_addr = addr_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BeatBytes);

    ddr_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEED       (SEED)
    ) u_wr_gen (
        .app_clk (app_clk),
        .rst     (rst),
        .load    (start_ok),
        .advance (wr_fire),
        .mode    (mode),
        .word    (app_data_wr)
    );

    ddr_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEED       (SEED)
    ) u_rd_gen (
        .app_clk (app_clk),
        .rst     (rst),
        .load    (start_ok),
        .advance (rd_beat),
        .mode    (mode),
        .word    (exp_word)
    );

`ifdef DDR_APP_TESTER_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        timeout_q;

    assign timeout_hit = (state_q == StRdData) && !app_data_rd_valid &&
                         (wdog_q == TimeoutLimit - 16'd1);
    assign timeout     = timeout_q;

    always_ff @(posedge app_clk) begin
        if (rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q != StRdData) || app_data_rd_valid) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + 16'd1;
            end
            if (start_ok) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StWrData;
            StWrData: if (wr_fire && (beat_q == LastBeat)) state_d = StWrAddr;
            StWrAddr: if (app_addr_wr_ready) state_d = (burst_q == LastBurst) ? StRdAddr : StWrData;
            StRdAddr: if (app_addr_rd_ready) state_d = StRdData;
            StRdData: begin
                if (rd_beat && (beat_q == LastBeat)) begin
                    state_d = (burst_q == LastBurst) ? StDone : StRdAddr;
                end else if (timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge app_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            burst_q     <= '0;
            addr_q      <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        beat_q      <= '0;
                        burst_q     <= '0;
                        addr_q      <= START_ADDR;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        pass_q      <= 1'b0;
                    end
                end
                StWrData: begin
                    if (app_data_wr_ready) begin
                        beat_q <= (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
                    end
                end
                StWrAddr: begin
                    // Read phase replays the same address sequence from burst 0.
                    if (app_addr_wr_ready) begin
                        if (burst_q == LastBurst) begin
                            burst_q <= '0;
                            addr_q  <= START_ADDR;
                        end else begin
                            burst_q <= burst_q + 16'd1;
                            addr_q  <= addr_q + BurstBytes;
                        end
                    end
                end
                StRdData: begin
                    if (app_data_rd_valid) begin
                        if (mismatch) begin
                            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                            if (err_cnt_q == 16'd0) first_err_q <= beat_addr;
                        end
                        if (beat_q == LastBeat) begin
                            beat_q  <= '0;
                            burst_q <= burst_q + 16'd1;
                            addr_q  <= addr_q + BurstBytes;
                        end else begin
                            beat_q <= beat_q + BeatW'(1);
                        end
                    end
                end
                StDone:  pass_q <= (err_cnt_q == 16'd0) && !timeout;
                default: ;
            endcase
        end
    end

    assign app_data_wr_valid = (state_q == StWrData);
    assign app_addr_wr_valid = (state_q == StWrAddr);
    assign app_addr_rd_valid = (state_q == StRdAddr);
    assign app_addr_wr       = addr_q;
    assign app_addr_rd       = addr_q;
    assign busy              = (state_q != StIdle);
    assign done              = (state_q == StDone);
    assign pass              = pass_q;
    assign err_cnt           = err_cnt_q;
    assign first_err_addr    = first_err_q;

endmodule

// File: tb/tb_ddr_app_tester.sv
// Scoreboard bench for ddr_app_tester with a loopback memory model.
module tb_ddr_app_tester;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;
    localparam int unsigned NB = 3;
    localparam logic [31:0]    Seed      = 32'h0000_0001;
    localparam logic [AW-1:0]  WrapStart = 30'h3FFF_FFF0;

    logic          app_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] app_data_wr;
    logic          app_data_wr_valid;
    logic          app_data_wr_ready = 1'b1;
    logic [AW-1:0] app_addr_wr;
    logic          app_addr_wr_valid;
    logic          app_addr_wr_ready = 1'b1;
    logic [AW-1:0] app_addr_rd;
    logic          app_addr_rd_valid;
    logic          app_addr_rd_ready = 1'b1;
    logic [DW-1:0] app_data_rd = '0;
    logic          app_data_rd_valid = 1'b0;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    logic          start_w = 1'b0;
    logic [DW-1:0] w_data_wr;
    logic          w_data_wr_valid, w_addr_wr_valid, w_addr_rd_valid;
    logic [AW-1:0] w_addr_wr, w_addr_rd, w_first_err;
    logic          w_busy, w_done, w_pass, w_timeout;
    logic [15:0]   w_err_cnt;

    ddr_app_tester #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BURST_LEN (BL), .NUM_BURSTS (NB),
        .START_ADDR ('0), .SEED (Seed)
    ) u_dut (
        .app_clk (app_clk), .rst (rst), .start (start), .mode (mode),
        .app_data_wr (app_data_wr), .app_data_wr_valid (app_data_wr_valid),
        .app_data_wr_ready (app_data_wr_ready),
        .app_addr_wr (app_addr_wr), .app_addr_wr_valid (app_addr_wr_valid),
        .app_addr_wr_ready (app_addr_wr_ready),
        .app_addr_rd (app_addr_rd), .app_addr_rd_valid (app_addr_rd_valid),
        .app_addr_rd_ready (app_addr_rd_ready),
        .app_data_rd (app_data_rd), .app_data_rd_valid (app_data_rd_valid),
        .busy (busy), .done (done), .pass (pass), .err_cnt (err_cnt),
        .first_err_addr (first_err_addr), .timeout (timeout)
    );

    ddr_app_tester #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BURST_LEN (BL), .NUM_BURSTS (2),
        .START_ADDR (WrapStart), .SEED (Seed)
    ) u_wrap (
        .app_clk (app_clk), .rst (rst), .start (start_w), .mode (1'b0),
        .app_data_wr (w_data_wr), .app_data_wr_valid (w_data_wr_valid),
        .app_data_wr_ready (1'b1),
        .app_addr_wr (w_addr_wr), .app_addr_wr_valid (w_addr_wr_valid),
        .app_addr_wr_ready (1'b1),
        .app_addr_rd (w_addr_rd), .app_addr_rd_valid (w_addr_rd_valid),
        .app_addr_rd_ready (1'b1),
        .app_data_rd ('0), .app_data_rd_valid (1'b0),
        .busy (w_busy), .done (w_done), .pass (w_pass), .err_cnt (w_err_cnt),
        .first_err_addr (w_first_err), .timeout (w_timeout)
    );

    always #5 app_clk = ~app_clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int ar_cyc   = 0;
    int done_cnt = 0;
    int rd_n     = 0;
    int corrupt_idx = -1;
    bit stall_en = 1'b0;
    bit junk_en  = 1'b0;
    bit withhold = 1'b0;

    logic [31:0]   exp_wd[$];
    logic [AW-1:0] exp_aw[$];
    logic [AW-1:0] exp_ar[$];
    logic [AW-1:0] w_exp_aw[$];
    logic [AW-1:0] w_exp_ar[$];
    logic [31:0]   wbuf[$];
    logic [31:0]   rd_pend[$];
    logic [31:0]   mem [logic [AW-1:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_model(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    always @(posedge app_clk) cyc <= cyc + 1;

    // Monitor: pops expected values whenever a handshake is about to complete.
    logic [31:0]   m_e32;
    logic [AW-1:0] m_ea;
    logic [AW-1:0] m_a;
    logic          prev_stalled = 1'b0;
    logic [31:0]   prev_data = '0;
    always @(negedge app_clk) begin
        if (rst) begin
            prev_stalled = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (app_data_wr_valid && prev_stalled) check("wr_data_stable", app_data_wr, prev_data);
            prev_stalled = app_data_wr_valid && !app_data_wr_ready;
            prev_data    = app_data_wr;
            if (app_data_wr_valid && app_data_wr_ready) begin
                if (exp_wd.size() != 0) m_e32 = exp_wd.pop_front(); else m_e32 = 'x;
                check("wr_data", app_data_wr, m_e32);
                wbuf.push_back(app_data_wr);
            end
            if (app_addr_wr_valid && app_addr_wr_ready) begin
                if (exp_aw.size() != 0) m_ea = exp_aw.pop_front(); else m_ea = 'x;
                check("wr_addr", app_addr_wr, m_ea);
                for (int i = 0; i < BL; i++) begin
                    if (wbuf.size() != 0) mem[app_addr_wr + AW'(4 * i)] = wbuf.pop_front();
                end
            end
            if (app_addr_rd_valid && app_addr_rd_ready) begin
                if (exp_ar.size() != 0) m_ea = exp_ar.pop_front(); else m_ea = 'x;
                check("rd_addr", app_addr_rd, m_ea);
                ar_cyc = cyc;
                for (int i = 0; i < BL; i++) begin
                    m_a = app_addr_rd + AW'(4 * i);
                    rd_pend.push_back(mem.exists(m_a) ? mem[m_a] : 32'hDEAD_BEEF);
                end
            end
            if (w_addr_wr_valid) begin
                if (w_exp_aw.size() != 0) m_ea = w_exp_aw.pop_front(); else m_ea = 'x;
                check("wrap_wr_addr", w_addr_wr, m_ea);
            end
            if (w_addr_rd_valid) begin
                if (w_exp_ar.size() != 0) m_ea = w_exp_ar.pop_front(); else m_ea = 'x;
                check("wrap_rd_addr", w_addr_rd, m_ea);
            end
        end
    end

    // Memory-side driver: readies and read data change just after the rising edge.
    initial begin
        logic [31:0] d;
        forever begin
            @(posedge app_clk);
            #1;
            if (stall_en) begin
                app_data_wr_ready = ($urandom_range(0, 3) != 0);
                app_addr_wr_ready = ($urandom_range(0, 2) != 0);
                app_addr_rd_ready = ($urandom_range(0, 2) != 0);
            end else begin
                app_data_wr_ready = 1'b1;
                app_addr_wr_ready = 1'b1;
                app_addr_rd_ready = 1'b1;
            end
            if (!rst && !withhold && rd_pend.size() != 0 &&
                (!stall_en || $urandom_range(0, 2) != 0)) begin
                d = rd_pend.pop_front();
                if (rd_n == corrupt_idx) d[0] = ~d[0];
                rd_n++;
                app_data_rd       = d;
                app_data_rd_valid = 1'b1;
            end else begin
                app_data_rd       = $urandom;
                app_data_rd_valid = junk_en && !rst && (rd_pend.size() == 0) &&
                                    ($urandom_range(0, 1) != 0);
            end
        end
    end

    task automatic load_expect(input logic m, input int rd_bursts);
        logic [31:0] s;
        s = Seed;
        for (int n = 0; n < BL * NB; n++) begin
            exp_wd.push_back(m ? s : Seed + 32'(n));
            s = lfsr_model(s);
        end
        for (int b = 0; b < NB; b++) exp_aw.push_back(AW'(b * BL * 4));
        for (int b = 0; b < rd_bursts; b++) exp_ar.push_back(AW'(b * BL * 4));
    endtask

    task automatic pulse_start(input logic m);
        @(posedge app_clk); #1;
        mode  = m;
        start = 1'b1;
        @(posedge app_clk); #1;
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge app_clk);
            if (done) break;
        end
        check("done_within_budget", done, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_first_err"}, first_err_addr, 0);
        check({tag, "_wd_valid"}, app_data_wr_valid, 0);
        check({tag, "_aw_valid"}, app_addr_wr_valid, 0);
        check({tag, "_ar_valid"}, app_addr_rd_valid, 0);
        check({tag, "_wr_data"}, app_data_wr, 0);
        check({tag, "_wr_addr"}, app_addr_wr, 0);
        check({tag, "_rd_addr"}, app_addr_rd, 0);
    endtask

    task automatic run_pass(input logic m, input bit stall, input int corrupt, input bit poke,
                            input logic [15:0] e_err, input logic [AW-1:0] e_first,
                            input logic e_pass);
        int d0;
        stall_en    = stall;
        corrupt_idx = corrupt;
        rd_n        = 0;
        d0          = done_cnt;
        load_expect(m, NB);
        pulse_start(m);
        if (poke) begin
            repeat (5) @(posedge app_clk);
            #1 start = 1'b1;
            @(posedge app_clk);
            #1 start = 1'b0;
        end
        wait_done(3000);
        check("err_cnt", err_cnt, e_err);
        check("first_err_addr", first_err_addr, e_first);
        check("busy_in_done", busy, 1);
        @(negedge app_clk);
        check("pass", pass, e_pass);
        check("timeout_clear", timeout, 0);
        check("busy_after_done", busy, 0);
        check("done_pulses", done_cnt - d0, 1);
        check("wr_q_drained", exp_wd.size(), 0);
        check("aw_q_drained", exp_aw.size(), 0);
        check("ar_q_drained", exp_ar.size(), 0);
        stall_en = 1'b0;
        corrupt_idx = -1;
    endtask

    initial begin
        #900_000;
        $display("FAIL global_time_limit: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "time limit");
    end

    initial begin
        int d0;
        repeat (3) @(posedge app_clk);
        @(negedge app_clk);
        check_quiet("reset");
        @(posedge app_clk); #1 rst = 1'b0;

        junk_en = 1'b1;
        run_pass(1'b0, 1'b0, -1, 1'b0, 16'd0, '0, 1'b1);
        junk_en = 1'b0;
        run_pass(1'b1, 1'b0, -1, 1'b0, 16'd0, '0, 1'b1);
        run_pass(1'b1, 1'b1, -1, 1'b1, 16'd0, '0, 1'b1);
        run_pass(1'b0, 1'b0, 5, 1'b0, 16'd1, AW'(20), 1'b0);

        // Abort mid-write; a fresh start must replay from SEED at burst 0.
        load_expect(1'b0, NB);
        pulse_start(1'b0);
        repeat (2) @(negedge app_clk);
        @(posedge app_clk); #1 rst = 1'b1;
        @(posedge app_clk);
        @(negedge app_clk);
        check_quiet("midrst");
        exp_wd.delete(); exp_aw.delete(); exp_ar.delete(); wbuf.delete(); rd_pend.delete();
        @(posedge app_clk); #1 rst = 1'b0;
        repeat (4) @(negedge app_clk);
        check("no_self_restart", busy, 0);
        run_pass(1'b0, 1'b1, -1, 1'b0, 16'd0, '0, 1'b1);

        // Wrapping start address on the second instance.
        w_exp_aw.push_back(WrapStart);
        w_exp_aw.push_back(AW'(0));
        w_exp_ar.push_back(WrapStart);
        @(posedge app_clk); #1 start_w = 1'b1;
        @(posedge app_clk); #1 start_w = 1'b0;
        repeat (30) @(negedge app_clk);
        check("wrap_aw_drained", w_exp_aw.size(), 0);
        check("wrap_ar_drained", w_exp_ar.size(), 0);

        // Read data withheld after the first read address.
        withhold = 1'b1;
        d0 = done_cnt;
        load_expect(1'b0, 1);
        pulse_start(1'b0);
`ifdef DDR_APP_TESTER_TIMEOUT_EN
        wait_done(4400);
        check("timeout_latency", cyc - ar_cyc, 4097);
        check("timeout_flag", timeout, 1);
        @(negedge app_clk);
        check("timeout_pass", pass, 0);
        check("timeout_busy", busy, 0);
        check("timeout_done_pulses", done_cnt - d0, 1);
        withhold = 1'b0;
        rd_pend.delete();
`else
        repeat (4400) @(negedge app_clk);
        check("stall_busy", busy, 1);
        check("stall_no_done", done_cnt - d0, 0);
        check("stall_timeout", timeout, 0);
        @(posedge app_clk); #1 rst = 1'b1;
        rd_pend.delete();
        withhold = 1'b0;
        @(posedge app_clk); #1 rst = 1'b0;
`endif
        check("final_wr_q", exp_wd.size(), 0);
        check("final_aw_q", exp_aw.size(), 0);
        check("final_ar_q", exp_ar.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ddr_app_tester.md
DDR_APP_TESTER -- requirements
Module: ddr_app_tester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; legal values are multiples of 32.
REQ-003 SHALL have parameter BURST_LEN, default 32, meaning beats per burst (1..1024).
REQ-004 SHALL have parameter NUM_BURSTS, default 100, meaning bursts per test pass (1..65535).
REQ-005 SHALL have parameter START_ADDR, default 0, meaning first burst byte address.
REQ-006 SHALL have parameter SEED, default 32'h0000_0001, meaning pattern seed.
REQ-007 SHALL have ports app_clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset); these come first.
REQ-008 SHALL have ports start (in, 1, pulse that begins a pass) and mode (in, 1, 0=incrementing, 1=LFSR; sampled at start).
REQ-009 SHALL have write ports app_data_wr (out, DATA_WIDTH), app_data_wr_valid (out, 1), app_data_wr_ready (in, 1), app_addr_wr (out, ADDR_WIDTH), app_addr_wr_valid (out, 1) and app_addr_wr_ready (in, 1).
REQ-010 SHALL have read ports app_addr_rd (out, ADDR_WIDTH), app_addr_rd_valid (out, 1), app_addr_rd_ready (in, 1), app_data_rd (in, DATA_WIDTH) and app_data_rd_valid (in, 1).
REQ-011 SHALL have status ports busy (out, 1), done (out, 1, one-cycle pulse), pass (out, 1), err_cnt (out, 16), first_err_addr (out, ADDR_WIDTH) and timeout (out, 1).

Function
REQ-012 SHALL implement states IDLE, WR_DATA, WR_ADDR, RD_ADDR, RD_DATA and DONE.
REQ-013 SHALL go IDLE->WR_DATA on start; start outside IDLE is ignored.
REQ-014 SHALL, in WR_DATA, hold app_data_wr_valid high, count a beat only on valid&&ready, and change app_data_wr only after an accepted beat.
REQ-015 SHALL go WR_DATA->WR_ADDR after BURST_LEN accepted beats, and present the burst's start address with app_addr_wr_valid until app_addr_wr_ready is seen.
REQ-016 SHALL make the address handshake go WR_ADDR->WR_DATA for the next burst, or ->RD_ADDR after NUM_BURSTS bursts, with the read burst index reset to 0.
REQ-017 SHALL, in RD_ADDR, issue the read address with app_addr_rd_valid until ready, then enter RD_DATA.
REQ-018 SHALL, in RD_DATA, compare each app_data_rd_valid beat against the regenerated expected word; after BURST_LEN beats go to RD_ADDR for the next burst, or to DONE after the last.
REQ-019 SHALL ignore app_data_rd_valid outside RD_DATA.
REQ-020 SHALL make DONE last one cycle, pulse done, then return to IDLE; pass = (err_cnt==0 && !timeout), held until the next start.
REQ-021 SHALL compute burst b's address as START_ADDR + b*BURST_LEN*(DATA_WIDTH/8), wrapping modulo 2^ADDR_WIDTH.
REQ-022 SHALL use global beat index n across all bursts; incrementing mode puts SEED+n in every 32-bit lane; LFSR mode uses a 32-bit Galois LFSR (poly 32'h8020_0003) seeded with SEED, advancing once per beat, lane k = state XOR k.
REQ-023 SHALL make err_cnt count mismatching beats, saturating at 16'hFFFF.
REQ-024 SHALL make first_err_addr capture the byte address of the first mismatching beat of the pass.
REQ-025 SHALL, on start, clear err_cnt, first_err_addr, pass and timeout, and reload both pattern generators.
REQ-026 SHALL hold busy high in every state except IDLE.

Reset
REQ-027 SHALL, while rst is high, force state IDLE, all valids 0, app_data_wr/app_addr_wr/app_addr_rd 0, err_cnt 0, first_err_addr 0, pass/done/busy/timeout 0, and counters 0.
REQ-028 SHALL make rst mid-pass abort immediately with no further valid asserted; a new start is required.

Configuration
REQ-029 SHALL, with DDR_APP_TESTER_TIMEOUT_EN defined, run a 16-bit watchdog in RD_DATA that reloads on every read beat; after 4096 idle cycles it sets timeout and goes to DONE (pass=0).
REQ-030 SHALL, without DDR_APP_TESTER_TIMEOUT_EN, tie timeout to 0 and let RD_DATA wait indefinitely.

Structure
REQ-031 SHALL place the state enum, mode encodings, LFSR polynomial and timeout constant in a shared package ddr_app_pkg.
REQ-032 SHALL use sub-module ddr_pattern_gen (load, advance, mode -> DATA_WIDTH word), instantiated twice: write generator and read-expected generator.

Verification
REQ-033 SHALL be verified by a loopback memory model with ready always 1, BURST_LEN=4, NUM_BURSTS=3, mode 0 -> write data SEED..SEED+11, write addresses 0/16/32, done with pass=1 and err_cnt=0.
REQ-034 SHALL be verified with random ready stalls on all three channels, mode 1 -> identical beat sequence to the no-stall case, pass=1.
REQ-035 SHALL be verified by corrupting read beat 5 (bit 0 flipped) -> err_cnt=1, first_err_addr=20, pass=0.
REQ-036 SHALL be verified with START_ADDR near the top, i.e. 2^30-16 with BURST_LEN=4 -> second burst address wraps to 0.
REQ-037 SHALL be verified by asserting rst during WR_DATA, then start -> all valids 0 next cycle; the new pass restarts from SEED at START_ADDR.
REQ-038 SHALL be verified with the timeout macro defined and read data withheld -> timeout=1 and done after 4096 cycles; without the macro, busy stays 1.
